// File: rtl/frm_irq_pkg.sv
// rtl/frm_irq_pkg.sv - shared state and cause definitions for the frame/line interrupt block
package frm_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } frm_state_e;

    localparam int N_CAUSE          = 4;
    localparam int CAUSE_FRM_DONE   = 0;
    localparam int CAUSE_LINE_MATCH = 1;
    localparam int CAUSE_LINE_ERR   = 2;
    localparam int CAUSE_FRM_ERR    = 3;

endpackage

// File: rtl/irq_sticky_reg.sv
// rtl/irq_sticky_reg.sv - sticky set / write-1-to-clear status with enable mask and registered irq
module irq_sticky_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] set,
    input  logic [W-1:0] clr,
    input  logic [W-1:0] en,
    output logic [W-1:0] status,
    output logic         irq
);

    logic [W-1:0] status_d, status_q;
    logic         irq_d, irq_q;

    // A set in the same cycle as a clear wins so that no event is ever lost.
    // irq follows the registered status, giving one extra cycle of latency.
    always_comb begin
        status_d = (status_q & ~clr) | set;
        irq_d    = |(status_q & en);
    end

    // Status and irq registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign status = status_q;
    assign irq    = irq_q;

endmodule

// File: rtl/frm_line_irq.sv
// rtl/frm_line_irq.sv - passive AXI4-Stream video frame/line event interrupt generator
module frm_line_irq
    import frm_irq_pkg::*;
#(
    parameter int VSIZE_W = 12,
    parameter int HSIZE_W = 12,
    parameter int FCNT_W  = 16
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tready,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    input  logic [VSIZE_W-1:0] img_vsize,
    input  logic [HSIZE_W-1:0] img_hsize,
    input  logic [VSIZE_W-1:0] line_match,
    input  logic [3:0]         irq_en,
    input  logic [3:0]         irq_clr,
    output logic [3:0]         irq_status,
    output logic               irq,
    output logic               frm_done_pulse,
    output logic [VSIZE_W-1:0] line_cnt,
    output logic [FCNT_W-1:0]  frm_cnt
);

    localparam logic [HSIZE_W-1:0] PIX_ONE  = HSIZE_W'(1);
    localparam logic [HSIZE_W-1:0] PIX_MAX  = '1;
    localparam logic [VSIZE_W-1:0] LINE_ONE = VSIZE_W'(1);
    localparam logic [FCNT_W-1:0]  FCNT_ONE = FCNT_W'(1);

    frm_state_e         state_d, state_q;
    logic [VSIZE_W-1:0] line_d, line_q;
    logic [HSIZE_W-1:0] pix_d, pix_q;
    logic [VSIZE_W-1:0] vsize_d, vsize_q;
    logic [HSIZE_W-1:0] hsize_d, hsize_q;
    logic [VSIZE_W-1:0] lmatch_d, lmatch_q;
    logic [FCNT_W-1:0]  frm_cnt_d, frm_cnt_q;
    logic               pulse_d, pulse_q;

    // Values seen by the end-of-line rules; a SOF beat replaces them first.
    frm_state_e         eff_state;
    logic [VSIZE_W-1:0] eff_line;
    logic [HSIZE_W-1:0] eff_pix;
    logic [VSIZE_W-1:0] eff_vsize;
    logic [HSIZE_W-1:0] eff_hsize;
    logic [VSIZE_W-1:0] eff_lmatch;
    logic [HSIZE_W-1:0] line_len;
    logic [N_CAUSE-1:0] cause_set;
    logic               beat;

    assign beat = s_axis_tvalid & s_axis_tready;

    // Frame tracking: SOF handling, pixel/line counting and cause detection.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        pix_d      = pix_q;
        vsize_d    = vsize_q;
        hsize_d    = hsize_q;
        lmatch_d   = lmatch_q;
        frm_cnt_d  = frm_cnt_q;
        pulse_d    = 1'b0;
        cause_set  = '0;
        eff_state  = state_q;
        eff_line   = line_q;
        eff_pix    = pix_q;
        eff_vsize  = vsize_q;
        eff_hsize  = hsize_q;
        eff_lmatch = lmatch_q;
        line_len   = '0;

        if (beat) begin
            if (s_axis_tuser) begin
                // Any progress in the current frame means it was cut short.
                if (state_q == ST_ACTIVE && (line_q != '0 || pix_q != '0)) begin
                    cause_set[CAUSE_FRM_ERR] = 1'b1;
                end
                vsize_d    = img_vsize;
                hsize_d    = img_hsize;
                lmatch_d   = line_match;
                line_d     = '0;
                pix_d      = PIX_ONE;
                state_d    = ST_ACTIVE;
                eff_state  = ST_ACTIVE;
                eff_vsize  = img_vsize;
                eff_hsize  = img_hsize;
                eff_lmatch = line_match;
                eff_line   = '0;
                eff_pix    = PIX_ONE;
            end

            line_len = (eff_pix == PIX_MAX) ? PIX_MAX : eff_pix + PIX_ONE;

            if (eff_state == ST_ACTIVE) begin
                if (s_axis_tlast) begin
                    if (eff_hsize != '0 && line_len != eff_hsize) begin
                        cause_set[CAUSE_LINE_ERR] = 1'b1;
                    end
                    if (eff_line == eff_lmatch) begin
                        cause_set[CAUSE_LINE_MATCH] = 1'b1;
                    end
                    if (eff_vsize != '0 && eff_line == eff_vsize - LINE_ONE) begin
                        cause_set[CAUSE_FRM_DONE] = 1'b1;
                        pulse_d   = 1'b1;
                        frm_cnt_d = frm_cnt_q + FCNT_ONE;
                        state_d   = ST_DONE;
                    end else begin
                        line_d = eff_line + LINE_ONE;
                        pix_d  = '0;
                    end
                end else if (!s_axis_tuser) begin
                    pix_d = line_len;
                end
            end else if (eff_state == ST_DONE) begin
                // Data after the last line of a frame without a new SOF.
                cause_set[CAUSE_FRM_ERR] = 1'b1;
            end
        end
    end

    // Tracking state, shadows and counters.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            pix_q     <= '0;
            vsize_q   <= '0;
            hsize_q   <= '0;
            lmatch_q  <= '0;
            frm_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            pix_q     <= pix_d;
            vsize_q   <= vsize_d;
            hsize_q   <= hsize_d;
            lmatch_q  <= lmatch_d;
            frm_cnt_q <= frm_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    irq_sticky_reg #(
        .W (N_CAUSE)
    ) u_sticky (
        .clk    (s_axis_aclk),
        .resetn (s_axis_aresetn),
        .set    (cause_set),
        .clr    (irq_clr),
        .en     (irq_en),
        .status (irq_status),
        .irq    (irq)
    );

    assign frm_done_pulse = pulse_q;
    assign line_cnt       = line_q;
    assign frm_cnt        = frm_cnt_q;

endmodule

// File: tb/tb_frm_line_irq.sv
// tb/tb_frm_line_irq.sv - directed self-checking bench for frm_line_irq
module tb_frm_line_irq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tvalid, tready, tuser, tlast;
    logic [11:0] img_vsize, img_hsize, line_match;
    logic [3:0]  irq_en, irq_clr;
    logic [3:0]  irq_status;
    logic        irq, frm_done_pulse;
    logic [11:0] line_cnt;
    logic [15:0] frm_cnt;

    int errors = 0;
    int checks = 0;

    frm_line_irq #(
        .VSIZE_W (12),
        .HSIZE_W (12),
        .FCNT_W  (16)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (resetn),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tuser   (tuser),
        .s_axis_tlast   (tlast),
        .img_vsize      (img_vsize),
        .img_hsize      (img_hsize),
        .line_match     (line_match),
        .irq_en         (irq_en),
        .irq_clr        (irq_clr),
        .irq_status     (irq_status),
        .irq            (irq),
        .frm_done_pulse (frm_done_pulse),
        .line_cnt       (line_cnt),
        .frm_cnt        (frm_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic u, input logic l);
        tvalid = 1'b1;
        tready = 1'b1;
        tuser  = u;
        tlast  = l;
        tick();
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_line(input int n, input logic sof);
        for (int i = 0; i < n; i++) begin
            beat(sof && (i == 0), i == n - 1);
        end
    endtask

    task automatic stall(input logic l);
        tvalid = 1'b1;
        tready = 1'b0;
        tlast  = l;
        tick();
        tvalid = 1'b0;
        tready = 1'b1;
        tlast  = 1'b0;
    endtask

    task automatic clr(input logic [3:0] m);
        irq_clr = m;
        tick();
        irq_clr = 4'h0;
    endtask

    initial begin
        resetn     = 1'b0;
        tvalid     = 1'b0;
        tready     = 1'b0;
        tuser      = 1'b0;
        tlast      = 1'b0;
        img_vsize  = 12'd4;
        img_hsize  = 12'd8;
        line_match = 12'd2;
        irq_en     = 4'b0011;
        irq_clr    = 4'h0;
        tick();
        tick();
        chk("rst_status", 32'(irq_status), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pulse", 32'(frm_done_pulse), 32'h0);
        chk("rst_line", 32'(line_cnt), 32'h0);
        chk("rst_frm", 32'(frm_cnt), 32'h0);
        resetn = 1'b1;
        tick();

        // Clean 4x8 frame
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        chk("s1_lmatch", 32'(irq_status), 32'h2);
        chk("s1_irq_lat", 32'(irq), 32'h0);
        chk("s1_line3", 32'(line_cnt), 32'h3);
        tick();
        chk("s1_irq", 32'(irq), 32'h1);
        send_line(8, 1'b0);
        chk("s1_done", 32'(irq_status), 32'h3);
        chk("s1_pulse", 32'(frm_done_pulse), 32'h1);
        chk("s1_frm", 32'(frm_cnt), 32'h1);
        tick();
        chk("s1_pulse_end", 32'(frm_done_pulse), 32'h0);
        clr(4'hF);
        chk("s1_clr", 32'(irq_status), 32'h0);
        tick();
        chk("s1_irq_clr", 32'(irq), 32'h0);

        // Short line 1
        send_line(8, 1'b1);
        send_line(7, 1'b0);
        chk("s2_lerr", 32'(irq_status), 32'h4);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        chk("s2_status", 32'(irq_status), 32'h7);
        chk("s2_frm", 32'(frm_cnt), 32'h2);
        clr(4'hF);

        // Truncated frame followed by a full one
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        beat(1'b1, 1'b0);
        chk("s3_trunc", 32'(irq_status), 32'h8);
        chk("s3_line0", 32'(line_cnt), 32'h0);
        send_line(7, 1'b0);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        chk("s3_status", 32'(irq_status), 32'hB);
        chk("s3_frm", 32'(frm_cnt), 32'h3);
        clr(4'hF);

        // Extra data after frame done
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0);
            chk("s4_no_pulse", 32'(frm_done_pulse), 32'h0);
        end
        chk("s4_extra", 32'(irq_status), 32'h8);
        chk("s4_frm_hold", 32'(frm_cnt), 32'h3);
        send_line(8, 1'b1);
        chk("s4_restart", 32'(line_cnt), 32'h1);
        chk("s4_sof_ok", 32'(irq_status), 32'h8);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        chk("s4_frm", 32'(frm_cnt), 32'h4);
        chk("s4_pulse", 32'(frm_done_pulse), 32'h1);
        clr(4'hF);
        tick();

        // Clear colliding with frame-done set
        irq_en = 4'b0001;
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        for (int i = 0; i < 7; i++) begin
            beat(1'b0, 1'b0);
        end
        irq_clr = 4'b0001;
        beat(1'b0, 1'b1);
        chk("s5_set_wins", 32'(irq_status), 32'h3);
        chk("s5_frm", 32'(frm_cnt), 32'h5);
        tick();
        irq_clr = 4'h0;
        chk("s5_cleared", 32'(irq_status), 32'h2);
        chk("s5_irq_hi", 32'(irq), 32'h1);
        tick();
        chk("s5_irq_lo", 32'(irq), 32'h0);
        irq_en = 4'b0011;
        clr(4'hF);

        // Stalls are not counted; reset mid-line discards the frame
        beat(1'b1, 1'b0);
        stall(1'b1);
        stall(1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            beat(1'b0, 1'b0);
        end
        beat(1'b0, 1'b1);
        chk("s6_stall_len", 32'(irq_status), 32'h0);
        chk("s6_line1", 32'(line_cnt), 32'h1);
        send_line(8, 1'b0);
        beat(1'b0, 1'b0);
        stall(1'b1);
        beat(1'b0, 1'b0);
        stall(1'b1);
        chk("s6_line2", 32'(line_cnt), 32'h2);
        chk("s6_no_cause", 32'(irq_status), 32'h0);
        resetn = 1'b0;
        tvalid = 1'b1;
        tready = 1'b1;
        tlast  = 1'b1;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("s6_rst_status", 32'(irq_status), 32'h0);
        chk("s6_rst_irq", 32'(irq), 32'h0);
        chk("s6_rst_pulse", 32'(frm_done_pulse), 32'h0);
        chk("s6_rst_line", 32'(line_cnt), 32'h0);
        chk("s6_rst_frm", 32'(frm_cnt), 32'h0);
        resetn = 1'b1;
        tick();
        send_line(8, 1'b0);
        chk("s6_idle_line", 32'(line_cnt), 32'h0);
        chk("s6_idle_status", 32'(irq_status), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
